// File: rtl/dda_pwr_pkg.sv
// Shared definitions for the DDA power sequencer: state encodings and widths.
// Optional retry behaviour is selected in the top by the DDA_PWR_RETRY_EN macro.
package dda_pwr_pkg;

    localparam int CNT_W   = 8;
    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_OFF     = 3'd0;
    localparam logic [STATE_W-1:0] ST_RAMP    = 3'd1;
    localparam logic [STATE_W-1:0] ST_ON      = 3'd2;
    localparam logic [STATE_W-1:0] ST_HOLDOFF = 3'd3;
    localparam logic [STATE_W-1:0] ST_FAULT   = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        S_OFF     = ST_OFF,
        S_RAMP    = ST_RAMP,
        S_ON      = ST_ON,
        S_HOLDOFF = ST_HOLDOFF,
        S_FAULT   = ST_FAULT
    } state_t;

endpackage

// File: rtl/dda_pwr_tick_counter.sv
// Clock-enable gated 8-bit tick counter with synchronous clear and terminal-count flag.
// done_o fires on the tick that would complete the terminal count.
module dda_pwr_tick_counter
    import dda_pwr_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] terminal_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q;

    // Saturates so long stays in ON/FAULT can never wrap back onto a terminal value.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_q <= '0;
        end else if (ce_i && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign done_o = ce_i && (count_q == terminal_i);

endmodule

// File: rtl/dda_power_sequencer.sv
// DDA power sequencer: min off-time, power ramp with IRS init timeout, loss detection, power cycle.
// Define DDA_PWR_RETRY_EN to retry timed-out ramps up to MAX_RETRY times before faulting.
module dda_power_sequencer
    import dda_pwr_pkg::*;
#(
    parameter     SENSE        = "SLOW",
    parameter int OFF_HOLD     = 10,
    parameter int INIT_TIMEOUT = 100,
    parameter int MAX_RETRY    = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               slow_ce_i,
    input  logic               micro_ce_i,
    input  logic               power_req_i,
    input  logic               power_cycle_i,
    input  logic               is_init_i,
    output logic               power_o,
    output logic               power_good_o,
    output logic               fault_o,
    output logic [STATE_W-1:0] state_o
);

    localparam bit USE_SLOW = (SENSE == "SLOW");

    state_t           state_q;
    state_t           state_d;
    logic             tick;
    logic             cnt_done;
    logic [CNT_W-1:0] terminal;
    logic             power_q;
    logic             good_q;
    logic             fault_q;

    assign tick     = USE_SLOW ? slow_ce_i : micro_ce_i;
    assign terminal = (state_q == S_HOLDOFF) ? CNT_W'(OFF_HOLD - 1) : CNT_W'(INIT_TIMEOUT - 1);

    dda_pwr_tick_counter u_tick_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ce_i       (tick),
        .clear_i    (state_d != state_q),
        .terminal_i (terminal),
        .done_o     (cnt_done)
    );

`ifdef DDA_PWR_RETRY_EN
    logic [1:0] retry_q;
    logic       retry_ok;
    logic       retry_take;

    assign retry_ok = (retry_q < 2'(MAX_RETRY));

    always_ff @(posedge clk_i) begin
        if (rst_i || !power_req_i || (state_d == S_ON && state_q != S_ON)) begin
            retry_q <= '0;
        end else if (retry_take) begin
            retry_q <= retry_q + 1'b1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
`ifdef DDA_PWR_RETRY_EN
        retry_take = 1'b0;
`endif
        case (state_q)
            S_OFF: begin
                if (power_req_i) state_d = S_RAMP;
            end
            S_RAMP: begin
                if (!power_req_i) begin
                    state_d = S_HOLDOFF;
                end else if (is_init_i) begin
                    state_d = S_ON;
                end else if (cnt_done) begin
`ifdef DDA_PWR_RETRY_EN
                    if (retry_ok) begin
                        state_d    = S_HOLDOFF;
                        retry_take = 1'b1;
                    end else begin
                        state_d = S_FAULT;
                    end
`else
                    state_d = S_FAULT;
`endif
                end
            end
            S_ON: begin
                if (!power_req_i)      state_d = S_HOLDOFF;
                else if (!is_init_i)   state_d = S_FAULT;
                else if (power_cycle_i) state_d = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (cnt_done) state_d = S_OFF;
            end
            S_FAULT: begin
                if (!power_req_i) state_d = S_HOLDOFF;
            end
            default: state_d = S_OFF;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with state_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_OFF;
            power_q <= 1'b0;
            good_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            power_q <= (state_d == S_RAMP) || (state_d == S_ON);
            good_q  <= (state_d == S_ON);
            fault_q <= (state_d == S_FAULT);
        end
    end

    assign power_o      = power_q;
    assign power_good_o = good_q;
    assign fault_o      = fault_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_dda_power_sequencer.sv
// Self-checking bench for dda_power_sequencer against a phase/tick reference model.
// Honours DDA_PWR_RETRY_EN the same way as the design.
module tb_dda_power_sequencer;

    localparam int OFF_HOLD     = 10;
    localparam int INIT_TIMEOUT = 100;
    localparam int MAX_RETRY    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       slow_ce;
    logic       micro_ce;
    logic       req;
    logic       cyc_p;
    logic       init;
    logic       power_o;
    logic       power_good_o;
    logic       fault_o;
    logic [2:0] state_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc_n       = 0;
    int hold_ticks  = 0;
    int ramp_ticks  = 0;

    // Reference model: phase (0 off,1 ramp,2 on,3 holdoff,4 fault), ticks seen in phase, retries used
    int m_ph    = 0;
    int m_ticks = 0;
    int m_retry = 0;

    always #5 clk = ~clk;

    dda_power_sequencer #(
        .SENSE        ("SLOW"),
        .OFF_HOLD     (OFF_HOLD),
        .INIT_TIMEOUT (INIT_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .slow_ce_i     (slow_ce),
        .micro_ce_i    (micro_ce),
        .power_req_i   (req),
        .power_cycle_i (cyc_p),
        .is_init_i     (init),
        .power_o       (power_o),
        .power_good_o  (power_good_o),
        .fault_o       (fault_o),
        .state_o       (state_o)
    );

    function automatic logic [5:0] got();
        return {state_o, power_o, power_good_o, fault_o};
    endfunction

    function automatic logic [5:0] want();
        return {3'(m_ph), (m_ph == 1 || m_ph == 2), (m_ph == 2), (m_ph == 4)};
    endfunction

    task automatic model_advance();
        int nph;
        bit tmo;
        if (rst) begin
            m_ph = 0; m_ticks = 0; m_retry = 0;
        end else begin
            nph = m_ph;
            tmo = 0;
            case (m_ph)
                0: if (req) nph = 1;
                1: begin
                    if (!req) nph = 3;
                    else if (init) nph = 2;
                    else if (slow_ce && m_ticks + 1 == INIT_TIMEOUT) tmo = 1;
                end
                2: begin
                    if (!req) nph = 3;
                    else if (!init) nph = 4;
                    else if (cyc_p) nph = 3;
                end
                3: if (slow_ce && m_ticks + 1 == OFF_HOLD) nph = 0;
                4: if (!req) nph = 3;
                default: nph = 0;
            endcase
            if (tmo) begin
`ifdef DDA_PWR_RETRY_EN
                if (m_retry < MAX_RETRY) begin
                    nph = 3;
                    m_retry++;
                end else begin
                    nph = 4;
                end
`else
                nph = 4;
`endif
            end
            if (!req || (nph == 2 && m_ph != 2)) m_retry = 0;
            if (nph != m_ph) m_ticks = 0;
            else if (slow_ce && m_ticks < 255) m_ticks++;
            m_ph = nph;
        end
    endtask

    // Called with clk low: applies ce for this cycle, advances model, returns at next negedge.
    task automatic tick_clk();
        slow_ce  = (cyc_n % 4 == 3);
        micro_ce = 1'($urandom_range(0, 1));
        if (state_o == 3'd3 && slow_ce) hold_ticks++;
        if (state_o == 3'd1 && slow_ce) ramp_ticks++;
        model_advance();
        @(posedge clk);
        #1;
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req = 1'($urandom_range(0, 1));
            tick_clk();
            vectors++;
            if (got() !== 6'b000_000) begin
                miscompares++;
                $display("[TB] FAIL reset_state: got %b want %b", got(), 6'b000_000);
            end
        end
        rst = 1'b0;
        req = 1'b0;
        tick_clk();
        vectors++;
        if (got() !== want()) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: got %b want %b", got(), want());
        end
    endtask

    task automatic test_power_up(input int init_ticks);
        int n;
        int guard;
        req  = 1'b1;
        init = 1'b0;
        tick_clk();
        vectors++;
        if (got() !== 6'b001_100) begin
            miscompares++;
            $display("[TB] FAIL req_to_power: got %b want %b", got(), 6'b001_100);
        end
        n = 0;
        guard = 0;
        while (n < init_ticks && guard < 1000) begin
            tick_clk();
            guard++;
            if (slow_ce) n++;
            vectors++;
            if (got() !== want()) begin
                miscompares++;
                $display("[TB] FAIL ramp_wait: got %b want %b", got(), want());
            end
        end
        init = 1'b1;
        tick_clk();
        vectors++;
        if (got() !== 6'b010_110) begin
            miscompares++;
            $display("[TB] FAIL init_to_good: got %b want %b", got(), 6'b010_110);
        end
        for (int i = 0; i < 5; i++) begin
            tick_clk();
            vectors++;
            if (got() !== want()) begin
                miscompares++;
                $display("[TB] FAIL on_hold: got %b want %b", got(), want());
            end
        end
    endtask

    task automatic test_release();
        int guard;
        int rereq_at;
        rereq_at   = $urandom_range(4, 30);
        hold_ticks = 0;
        req = 1'b0;
        tick_clk();
        init = 1'b0;
        vectors++;
        if (got() !== 6'b011_000) begin
            miscompares++;
            $display("[TB] FAIL release_holdoff: got %b want %b", got(), 6'b011_000);
        end
        guard = 0;
        while (m_ph != 1 && guard < 200) begin
            if (guard == rereq_at) req = 1'b1;
            tick_clk();
            guard++;
            vectors++;
            if (got() !== want()) begin
                miscompares++;
                $display("[TB] FAIL release_seq: got %b want %b", got(), want());
            end
        end
        vectors++;
        if (hold_ticks != OFF_HOLD || m_ph != 1) begin
            miscompares++;
            $display("[TB] FAIL release_hold_len: got %0d ticks want %0d", hold_ticks, OFF_HOLD);
        end
        test_power_up($urandom_range(2, 12));
    endtask

    task automatic test_power_cycle();
        int guard;
        hold_ticks = 0;
        cyc_p = 1'b1;
        tick_clk();
        cyc_p = 1'b0;
        init  = 1'b0;
        vectors++;
        if (got() !== 6'b011_000) begin
            miscompares++;
            $display("[TB] FAIL cycle_holdoff: got %b want %b", got(), 6'b011_000);
        end
        guard = 0;
        while (m_ph != 1 && guard < 200) begin
            tick_clk();
            guard++;
            vectors++;
            if (got() !== want()) begin
                miscompares++;
                $display("[TB] FAIL cycle_seq: got %b want %b", got(), want());
            end
        end
        vectors++;
        if (hold_ticks != OFF_HOLD || m_ph != 1) begin
            miscompares++;
            $display("[TB] FAIL cycle_off_len: got %0d ticks want %0d", hold_ticks, OFF_HOLD);
        end
        test_power_up($urandom_range(1, 10));
    endtask

    task automatic test_timeout();
        int guard;
        int windows;
        req = 1'b0;
        init = 1'b0;
        guard = 0;
        while (m_ph != 0 && guard < 200) begin
            tick_clk();
            guard++;
        end
        req = 1'b1;
        ramp_ticks = 0;
        guard = 0;
        while (m_ph != 4 && guard < 3000) begin
            cyc_p = 1'($urandom_range(0, 7) == 0);
            tick_clk();
            guard++;
            vectors++;
            if (got() !== want()) begin
                miscompares++;
                $display("[TB] FAIL timeout_seq: got %b want %b", got(), want());
            end
        end
        cyc_p = 1'b0;
`ifdef DDA_PWR_RETRY_EN
        windows = MAX_RETRY + 1;
`else
        windows = 1;
`endif
        vectors++;
        if (ramp_ticks != INIT_TIMEOUT * windows || got() !== 6'b100_001) begin
            miscompares++;
            $display("[TB] FAIL timeout_fault: got %0d ticks state %b want %0d ticks state %b",
                     ramp_ticks, got(), INIT_TIMEOUT * windows, 6'b100_001);
        end
        req = 1'b0;
        tick_clk();
        vectors++;
        if (got() !== 6'b011_000) begin
            miscompares++;
            $display("[TB] FAIL fault_clear: got %b want %b", got(), 6'b011_000);
        end
        guard = 0;
        while (m_ph != 0 && guard < 200) begin
            tick_clk();
            guard++;
            vectors++;
            if (got() !== want()) begin
                miscompares++;
                $display("[TB] FAIL fault_recover: got %b want %b", got(), want());
            end
        end
    endtask

    task automatic test_init_loss();
        int guard;
        test_power_up($urandom_range(1, 8));
        init = 1'b0;
        tick_clk();
        vectors++;
        if (got() !== 6'b100_001) begin
            miscompares++;
            $display("[TB] FAIL init_loss_fault: got %b want %b", got(), 6'b100_001);
        end
        req = 1'b0;
        guard = 0;
        while (m_ph != 0 && guard < 200) begin
            tick_clk();
            guard++;
        end
        test_power_up($urandom_range(1, 8));
        init = 1'b0;
        req  = 1'b0;
        tick_clk();
        vectors++;
        if (got() !== 6'b011_000) begin
            miscompares++;
            $display("[TB] FAIL req_beats_loss: got %b want %b", got(), 6'b011_000);
        end
        guard = 0;
        while (m_ph != 1 && guard < 200) begin
            if (guard > 3) req = 1'b1;
            tick_clk();
            guard++;
        end
        for (int i = 0; i < int'($urandom_range(1, 20)); i++) tick_clk();
        rst = 1'b1;
        tick_clk();
        rst = 1'b0;
        vectors++;
        if (got() !== 6'b000_000) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ramp: got %b want %b", got(), 6'b000_000);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst   = 1'($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) req = ~req;
            cyc_p = 1'($urandom_range(0, 24) == 0);
            if (!power_o) init = 1'b0;
            else if ($urandom_range(0, 39) == 0) init = ~init;
            tick_clk();
            vectors++;
            if (got() !== want()) begin
                miscompares++;
                $display("[TB] FAIL random_%0d: got %b want %b", i, got(), want());
            end
        end
        rst = 1'b0;
        cyc_p = 1'b0;
    endtask

    initial begin
        rst = 1'b1; slow_ce = 1'b0; micro_ce = 1'b0;
        req = 1'b0; cyc_p = 1'b0; init = 1'b0;
        @(negedge clk);
        test_reset();
        test_power_up(20);
        test_release();
        test_power_cycle();
        test_timeout();
        test_init_loss();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
